alu_control_stage: RTL



---
 rtl/alu_control_stage_if.sv | 24 ++
 rtl/alu_control_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_stage_if.sv
// Handshake bundle between fetch, the ALU control decode stage and execute.
// The stage itself uses the slave view; the surrounding pipeline uses master.
interface alu_control_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  alu_ctl;
    logic [31:0] imm;
    logic        b_imm;
    logic        a_uimm;
    logic        illegal;

    modport slave (
        input  in_valid, instr, out_ready,
        output in_ready, out_valid, alu_ctl, imm, b_imm, a_uimm, illegal
    );

    modport master (
        output in_valid, instr, out_ready,
        input  in_ready, out_valid, alu_ctl, imm, b_imm, a_uimm, illegal
    );
endinterface

// File: rtl/alu_control_stage.sv
// RV32I decode stage producing the ALU control word, immediate and operand
// selects, buffered in a two-entry skid queue with ready/valid on both sides.
module alu_control_stage (
    input  logic                clk,
    input  logic                rst,
    alu_control_stage_if.slave  bus
);

    typedef struct packed {
        logic [6:0]  alu_ctl;
        logic [31:0] imm;
        logic        b_imm;
        logic        a_uimm;
        logic        illegal;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fill_e;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b0011;
    localparam logic [3:0] OP_SRA  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_CSRW = 4'b1001;
    localparam logic [3:0] OP_CSRS = 4'b1010;
    localparam logic [3:0] OP_CSRC = 4'b1011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Shared by OP and OP-IMM; alt_ok is cleared for OP-IMM so SUB is never formed.
    function automatic logic [4:0] arith_op(input logic [2:0] f3,
                                            input logic [6:0] f7,
                                            input logic       f7_checked,
                                            input logic       alt_ok);
        logic [3:0] op;
        logic       bad;
        op  = OP_AND;
        bad = 1'b0;
        case (f3)
            3'b000: begin
                if (!f7_checked) begin
                    op = OP_ADD;
                end else if (f7 == F7_BASE) begin
                    op = OP_ADD;
                end else if ((f7 == F7_ALT) && alt_ok) begin
                    op = OP_SUB;
                end else begin
                    bad = 1'b1;
                end
            end
            3'b001:  begin op = OP_SLL; bad = (f7 != F7_BASE); end
            3'b010:  begin op = OP_SLT; bad = f7_checked && (f7 != F7_BASE); end
            3'b100:  begin op = OP_XOR; bad = f7_checked && (f7 != F7_BASE); end
            3'b110:  begin op = OP_OR;  bad = f7_checked && (f7 != F7_BASE); end
            3'b111:  begin op = OP_AND; bad = f7_checked && (f7 != F7_BASE); end
            3'b101: begin
                if (f7 == F7_BASE) begin
                    op = OP_SRL;
                end else if (f7 == F7_ALT) begin
                    op = OP_SRA;
                end else begin
                    bad = 1'b1;
                end
            end
            default: bad = 1'b1;
        endcase
        return {bad, op};
    endfunction

    function automatic entry_t decode(input logic [31:0] w);
        entry_t     e;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [4:0] ar;
        f3 = w[14:12];
        f7 = w[31:25];
        e  = entry_t'(42'd0);
        ar = 5'd0;
        case (w[6:0])
            7'b0110011: begin
                ar = arith_op(f3, f7, 1'b1, 1'b1);
                e.alu_ctl = {3'b000, ar[3:0]};
                e.illegal = ar[4];
            end
            7'b0010011: begin
                // Only the shift forms reuse imm[11:5] as a funct7 field.
                ar = arith_op(f3, f7, 1'b0, 1'b0);
                e.alu_ctl = {3'b000, ar[3:0]};
                e.illegal = ar[4];
                e.b_imm   = 1'b1;
                e.imm     = {{20{w[31]}}, w[31:20]};
            end
            7'b0000011: begin
                e.alu_ctl = {3'b000, OP_ADD};
                e.b_imm   = 1'b1;
                e.imm     = {{20{w[31]}}, w[31:20]};
            end
            7'b0100011: begin
                e.alu_ctl = {3'b000, OP_ADD};
                e.b_imm   = 1'b1;
                e.imm     = {{20{w[31]}}, w[31:25], w[11:7]};
            end
            7'b1100011: begin
                e.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
                case (f3)
                    3'b000:  e.alu_ctl = {3'b001, OP_SUB};
                    3'b001:  e.alu_ctl = {3'b010, OP_SUB};
                    3'b100:  e.alu_ctl = {3'b011, OP_SUB};
                    3'b101:  e.alu_ctl = {3'b100, OP_SUB};
                    3'b110:  e.alu_ctl = {3'b101, OP_SUB};
                    3'b111:  e.alu_ctl = {3'b110, OP_SUB};
                    default: e.illegal = 1'b1;
                endcase
            end
            7'b0110111, 7'b0010111: begin
                e.alu_ctl = {3'b000, OP_ADD};
                e.b_imm   = 1'b1;
                e.imm     = {w[31:12], 12'd0};
            end
            7'b1101111: begin
                e.alu_ctl = {3'b000, OP_ADD};
                e.imm     = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            end
            7'b1100111: begin
                e.alu_ctl = {3'b000, OP_ADD};
                e.b_imm   = 1'b1;
                e.imm     = {{20{w[31]}}, w[31:20]};
                e.illegal = (f3 != 3'b000);
            end
            7'b1110011: begin
                case (f3[1:0])
                    2'b01:   e.alu_ctl = {3'b000, OP_CSRW};
                    2'b10:   e.alu_ctl = {3'b000, OP_CSRS};
                    2'b11:   e.alu_ctl = {3'b000, OP_CSRC};
                    default: e.illegal = 1'b1;
                endcase
                e.a_uimm = f3[2];
                if (f3[2]) begin
                    e.imm = {27'd0, w[19:15]};
                end else begin
                    e.imm = 32'd0;
                end
            end
            default: e.illegal = 1'b1;
        endcase
        // Illegal entries carry no decode information at all.
        if (e.illegal) begin
            e = entry_t'(42'd0);
            e.illegal = 1'b1;
        end else begin
            e.illegal = 1'b0;
        end
        return e;
    endfunction

    fill_e  fill_r, fill_s;
    entry_t head_r, head_s;
    entry_t tail_r, tail_s;
    entry_t dec_s;
    logic   push_s;
    logic   pop_s;

    assign bus.in_ready  = (fill_r != FULL);
    assign bus.out_valid = (fill_r != EMPTY);
    assign bus.alu_ctl   = head_r.alu_ctl;
    assign bus.imm       = head_r.imm;
    assign bus.b_imm     = head_r.b_imm;
    assign bus.a_uimm    = head_r.a_uimm;
    assign bus.illegal   = head_r.illegal;

    assign push_s = bus.in_valid & (fill_r != FULL);
    assign pop_s  = (fill_r != EMPTY) & bus.out_ready;

    // Decode of the instruction currently offered by fetch.
    always_comb begin
        dec_s = decode(bus.instr);
    end

    // Next fill state and entry contents from push/pop.
    always_comb begin
        fill_s = fill_r;
        head_s = head_r;
        tail_s = tail_r;
        case (fill_r)
            EMPTY: begin
                if (push_s) begin
                    head_s = dec_s;
                    fill_s = ONE;
                end else begin
                    fill_s = EMPTY;
                end
            end
            ONE: begin
                if (push_s && pop_s) begin
                    head_s = dec_s;
                end else if (push_s) begin
                    tail_s = dec_s;
                    fill_s = FULL;
                end else if (pop_s) begin
                    fill_s = EMPTY;
                end else begin
                    fill_s = ONE;
                end
            end
            FULL: begin
                // No push is possible here: in_ready is low while full.
                if (pop_s) begin
                    head_s = tail_r;
                    fill_s = ONE;
                end else begin
                    fill_s = FULL;
                end
            end
            default: fill_s = EMPTY;
        endcase
    end

    // Buffer state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_r <= EMPTY;
            head_r <= entry_t'(42'd0);
            tail_r <= entry_t'(42'd0);
        end else begin
            fill_r <= fill_s;
            head_r <= head_s;
            tail_r <= tail_s;
        end
    end

endmodule
